audio_dac_tx: RTL and testbench

- Codec-side counterpart to the music sequencer FSMs: runs the codec start-up handshake (INIT in, INIT_FINISH out), then serializes stereo PCM samples onto the DAC I2S pins.
- Pulses data_over once per consumed stereo frame, so the sequencer knows when to advance its ROM address.
- Sits between the sample mixer/ROM and the WM8731 DAC pins.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_bclk_gen.sv | 38 +++
 rtl/audio_dac_tx.sv | 131 +++++++++++++
 tb/tb_audio_dac_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state type and default parameters for the DAC transmitter
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INIT_WAIT = 2'd1,
        RUN       = 2'd2
    } dac_state_e;

    localparam int DEF_SAMPLE_W    = 16;
    localparam int DEF_BCLK_HALF   = 2;
    localparam int DEF_INIT_CYCLES = 1000;

endpackage

// File: rtl/audio_bclk_gen.sv
// rtl/audio_bclk_gen.sv - bit clock divider with a strobe marking the cycle BCLK falls
module audio_bclk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_HALF = DEF_BCLK_HALF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic enable_i,
    output logic bclk_o,
    output logic fall_evt_o
);

    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DW-1:0] div_cnt_q;
    logic          bclk_q;
    logic          wrap;

    assign wrap = (div_cnt_q == DW'(BCLK_HALF - 1));

    always_ff @(posedge Clk) begin
        if (Reset || !enable_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else if (wrap) begin
            div_cnt_q <= '0;
            bclk_q    <= ~bclk_q;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // Combinational so the top can update its outputs on the very edge BCLK falls.
    assign fall_evt_o = enable_i && wrap && bclk_q;
    assign bclk_o     = bclk_q;

endmodule

// File: rtl/audio_dac_tx.sv
// rtl/audio_dac_tx.sv - codec init handshake and I2S stereo serializer for the WM8731 DAC
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int BCLK_HALF   = DEF_BCLK_HALF,
    parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                INIT,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                mute,
    output logic                INIT_FINISH,
    output logic                data_over,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT
);

    localparam int FW = 2 * SAMPLE_W;
    localparam int BW = $clog2(FW);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_SLOT = BW'(FW - 1);

    dac_state_e      state_q, state_d;
    logic [IW-1:0]   init_cnt_q, init_cnt_d;

    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]   bit_nxt;
    logic [FW-1:0]   shift_q, shift_d;
    logic            prev_lsb_q, prev_lsb_d;
    logic            dat_q, dat_d;
    logic            lrck_q, lrck_d;
    logic            dov_q, dov_d;
    logic            fall_evt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            IDLE: begin
                if (INIT) begin
                    state_d    = INIT_WAIT;
                    init_cnt_d = '0;
                end
            end
            INIT_WAIT: begin
                if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    audio_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .enable_i   (state_q == RUN),
        .bclk_o     (AUD_BCLK),
        .fall_evt_o (fall_evt)
    );

    assign bit_nxt = (bit_cnt_q == LAST_SLOT) ? '0 : bit_cnt_q + 1'b1;

    // The frame is held as {L, R} and shifted MSB-first; slot 0 replays the previous R LSB.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        prev_lsb_d = prev_lsb_q;
        dat_d      = dat_q;
        lrck_d     = lrck_q;
        dov_d      = 1'b0;
        if (fall_evt) begin
            bit_cnt_d = bit_nxt;
            lrck_d    = (bit_nxt >= BW'(SAMPLE_W));
            if (bit_nxt == '0) begin
                shift_d = mute ? '0 : {sample_l, sample_r};
                dov_d   = 1'b1;
                dat_d   = prev_lsb_q;
            end else begin
                dat_d   = shift_q[FW-1];
                shift_d = {shift_q[FW-2:0], 1'b0};
            end
            if (bit_nxt == LAST_SLOT) begin
                prev_lsb_d = shift_q[FW-2];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bit_cnt_q  <= LAST_SLOT;
            shift_q    <= '0;
            prev_lsb_q <= 1'b0;
            dat_q      <= 1'b0;
            lrck_q     <= 1'b1;
            dov_q      <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            prev_lsb_q <= prev_lsb_d;
            dat_q      <= dat_d;
            lrck_q     <= lrck_d;
            dov_q      <= dov_d;
        end
    end

    assign INIT_FINISH = (state_q == RUN);
    assign data_over   = dov_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb/tb_audio_dac_tx.sv - directed self-checking bench for audio_dac_tx
module tb_audio_dac_tx;

    localparam int SAMPLE_W    = 16;
    localparam int BCLK_HALF   = 2;
    localparam int INIT_CYCLES = 10;
    localparam int FRAME_CLK   = 4 * SAMPLE_W * BCLK_HALF;

    logic                Clk = 1'b0;
    logic                Reset;
    logic                INIT;
    logic [SAMPLE_W-1:0] sample_l;
    logic [SAMPLE_W-1:0] sample_r;
    logic                mute;
    logic                INIT_FINISH;
    logic                data_over;
    logic                AUD_BCLK;
    logic                AUD_DACLRCK;
    logic                AUD_DACDAT;

    int n_checks = 0;
    int n_pass   = 0;

    audio_dac_tx #(
        .SAMPLE_W    (SAMPLE_W),
        .BCLK_HALF   (BCLK_HALF),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .INIT        (INIT),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .mute        (mute),
        .INIT_FINISH (INIT_FINISH),
        .data_over   (data_over),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // INIT accepted at edge n; RUN entered at n+INIT_CYCLES; first BCLK fall 4 Clk later.
    task automatic init_seq(input string tag, input bit hold);
        int bad;
        bad = 0;
        INIT = 1'b1;
        tick();
        if (!hold) INIT = 1'b0;
        for (int i = 1; i < INIT_CYCLES; i++) begin
            if (hold) INIT = ~INIT;
            tick();
            if (INIT_FINISH !== 1'b0 || AUD_BCLK !== 1'b0 || data_over !== 1'b0) bad++;
        end
        chk({tag, "_early"}, bad, 0);
        if (hold) INIT = 1'b1;
        tick();
        chk({tag, "_finish"}, INIT_FINISH, 1'b1);
        tick();
        chk({tag, "_bclk_m1"}, AUD_BCLK, 1'b0);
        tick();
        chk({tag, "_bclk_rise"}, AUD_BCLK, 1'b1);
        tick();
        chk({tag, "_bclk_m3"}, AUD_BCLK, 1'b1);
        tick();
        chk({tag, "_bclk_fall"}, {AUD_BCLK, data_over, AUD_DACLRCK, AUD_DACDAT}, 4'b0100);
    endtask

    // Runs one frame from just after a data_over edge to the next one, capturing bits on BCLK rise.
    task automatic run_frame(input string tag, input logic exp_s0,
                             input logic [15:0] exp_l, input logic [15:0] exp_r);
        logic        prev;
        logic        s0;
        logic [15:0] lw;
        logic [14:0] rhi;
        int          slot, dov_cnt, dov_at, lrck_bad;
        prev = AUD_BCLK;
        slot = 0; dov_cnt = 0; dov_at = -1; lrck_bad = 0;
        s0 = 1'bx; lw = 'x; rhi = 'x;
        for (int t = 1; t <= FRAME_CLK; t++) begin
            tick();
            if (AUD_BCLK && !prev) begin
                if (slot == 0) s0 = AUD_DACDAT;
                else if (slot <= 16) lw[16-slot] = AUD_DACDAT;
                else rhi[31-slot] = AUD_DACDAT;
                if (AUD_DACLRCK !== (slot >= 16)) lrck_bad++;
            end
            if (!AUD_BCLK && prev) slot++;
            if (data_over) begin
                dov_cnt++;
                dov_at = t;
            end
            prev = AUD_BCLK;
        end
        chk({tag, "_slot0"}, s0, exp_s0);
        chk({tag, "_left"}, lw, exp_l);
        chk({tag, "_right_hi"}, rhi, exp_r[15:1]);
        chk({tag, "_lrck"}, lrck_bad, 0);
        chk({tag, "_dov_cnt"}, dov_cnt, 1);
        chk({tag, "_dov_at"}, dov_at, FRAME_CLK);
    endtask

    initial begin
        int cnt;
        Reset    = 1'b1;
        INIT     = 1'b0;
        mute     = 1'b0;
        sample_l = 16'hA5C3;
        sample_r = 16'h1234;
        repeat (3) tick();
        chk("rst_outputs", {INIT_FINISH, data_over, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}, 5'b00010);
        Reset = 1'b0;
        repeat (2) tick();
        chk("idle_no_init", {INIT_FINISH, AUD_BCLK}, 2'b00);

        init_seq("init1", 1'b0);
        run_frame("frameA", 1'b0, 16'hA5C3, 16'h1234);

        sample_l = 16'hFFFF;
        sample_r = 16'h1235;
        run_frame("frameB", 1'b0, 16'hA5C3, 16'h1234);

        mute = 1'b1;
        run_frame("frameC", 1'b0, 16'hFFFF, 16'h1235);
        mute = 1'b0;
        run_frame("frameD_mute", 1'b1, 16'h0000, 16'h0000);

        repeat (81) tick();
        chk("pre_reset_lrck", AUD_DACLRCK, 1'b1);
        Reset = 1'b1;
        tick();
        chk("mid_reset", {INIT_FINISH, data_over, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}, 5'b00010);
        Reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (data_over || INIT_FINISH || AUD_BCLK || AUD_DACDAT) cnt++;
        end
        chk("post_reset_quiet", cnt, 0);

        init_seq("init2", 1'b1);
        run_frame("frameF", 1'b0, 16'hFFFF, 16'h1235);
        chk("run_sticky", INIT_FINISH, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
